arbitro_barramento: RTL
=======================

// Module: arbitro_barramento
// PURPOSE
//   Round-robin arbiter and sequencer for the shared N-port data bus (Barramento).
//   Takes per-port write/read requests (ctrl bit 1 = escrever, bit 0 = ler).
//   Grants bus ownership to exactly one writer at a time and muxes that writer's data onto the bus.
//   Strobes the reading ports and enforces a burst limit plus a turnaround cycle between owners.
// PARAMETERS
//   N_PORTAS    6   number of bus ports
//   LARGURA     16  bus data width, bits
//   MAX_RAJADA  4   max consecutive granted cycles per owner while others wait (>=1)
// PORTS
//   clk            in   1                   system clock, rising edge
//   rst_n          in   1                   synchronous reset, active-low
//   req_escrita    in   N_PORTAS            per-port write request (ctrl_i[1])
//   req_leitura    in   N_PORTAS            per-port read request (ctrl_i[0])
//   dado_in        in   N_PORTAS*LARGURA    port write data, port i at [i*LARGURA +: LARGURA]
//   grant          out  N_PORTAS            one-hot write grant, registered
//   dono           out  $clog2(N_PORTAS)    index of current owner (valid when ocupado=1)
//   ocupado        out  1                   bus owned (state CONCEDIDO)
//   dado_barramento out LARGURA             bus data = dado_in of owner, else 0
//   valido         out  1                   dado_barramento carries a live write this cycle
//   ler_en         out  N_PORTAS            per-port read strobe: latch dado_barramento this edge
// BEHAVIOUR
//   Reset (rst_n=0 at rising edge):
//     - grant=0, dono=0, ocupado=0, valido=0, ler_en=0, dado_barramento=0.
//     - state=OCIOSO, cont_rajada=0, ultimo=N_PORTAS-1, so port 0 has first priority.
//     - Reset mid-grant drops ownership on that edge; no partial transfer is reported.
//   FSM states: OCIOSO, CONCEDIDO, RETORNO.
//     OCIOSO:
//       - If any req_escrita: pick first requester scanning ultimo+1, ultimo+2, ... (mod N_PORTAS).
//       - Next state CONCEDIDO, grant/dono set, cont_rajada=1.
//       - Latency is 1 cycle: request seen at edge t gives grant visible after edge t.
//     CONCEDIDO:
//       - If req_escrita[dono]=0: go to RETORNO, ultimo=dono, grant=0.
//       - Else if cont_rajada==MAX_RAJADA and another port requests write: go to RETORNO, ultimo=dono.
//       - Else if cont_rajada==MAX_RAJADA and no other port requests: stay, cont_rajada=1 (no saturation).
//       - Else: stay, cont_rajada+1.
//     RETORNO:
//       - Bus idle exactly 1 cycle (grant=0, valido=0), then OCIOSO arbitration rules apply on next edge.
//       - Requests during RETORNO are evaluated at its exit edge, so the next grant follows RETORNO directly.
//   Datapath (combinational from registered state):
//     - valido = ocupado & req_escrita[dono].
//     - dado_barramento = valido ? dado_in[dono] : 0.
//     - ler_en[i] = valido & req_leitura[i] & ~grant[i]; owner never reads its own write.
//     - Multiple readers may be strobed simultaneously (broadcast).
//   Priority and fairness:
//     - Write request outranks read request on the same port.
//     - Worst-case wait for a requester = (N_PORTAS-1)*(MAX_RAJADA+1) cycles after request.
//   Boundaries:
//     - Owner drops request in the same cycle another raises it: RETORNO, then round-robin from dono+1.
//     - Single requester: never starved, never preempted.
//     - Wrap-around: ultimo=N_PORTAS-1 scans from port 0.
//     - grant is always one-hot or zero; dono is stable for the whole grant.
// TESTING
//   1 Reset: hold rst_n=0 with req_escrita=6'h3F -> grant=0, valido=0; on first edge with rst_n=1, grant=6'h01.
//   2 Single writer: port 2 writes 16'hA5A5 for 10 cycles, port 4 reads.
//       -> grant=6'h04 from cycle 1, ler_en=6'h10 while valido=1.
//       -> dado_barramento=16'hA5A5, no RETORNO inserted.
//   3 Round-robin: ports 0, 3, 5 request continuously, MAX_RAJADA=4.
//       -> owners 0,3,5,0,... each for 4 cycles, each followed by 1 idle RETORNO cycle.
//   4 Early release: port 1 owns, drops req after 2 cycles while port 1 and port 5 request again.
//       -> RETORNO 1 cycle, then port 5 is granted (not port 1).
//   5 Self-read: port 3 asserts ctrl=2'b11 and owns the bus -> ler_en[3]=0; other readers strobed.
//   6 Mid-op reset: rst_n=0 during a burst -> grant=0 after that edge; after release, port 0 has priority.

Source files
------------

// File: rtl/arbitro_barramento.sv
// Round-robin write arbiter and sequencer for the shared N-port bus (Barramento).
// One writer owns the bus at a time. Its data is muxed onto the bus and every
// other reading port is strobed. A burst limit applies while others wait, and a
// one-cycle turnaround separates consecutive owners.
module arbitro_barramento #(
    parameter int unsigned N_PORTAS   = 6,
    parameter int unsigned LARGURA    = 16,
    parameter int unsigned MAX_RAJADA = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_PORTAS-1:0]           req_escrita,
    input  logic [N_PORTAS-1:0]           req_leitura,
    input  logic [N_PORTAS*LARGURA-1:0]   dado_in,
    output logic [N_PORTAS-1:0]           grant,
    output logic [$clog2(N_PORTAS)-1:0]   dono,
    output logic                          ocupado,
    output logic [LARGURA-1:0]            dado_barramento,
    output logic                          valido,
    output logic [N_PORTAS-1:0]           ler_en
);

    localparam int unsigned IdxW  = $clog2(N_PORTAS);
    localparam int unsigned ContW = $clog2(MAX_RAJADA + 1);

    typedef enum logic [1:0] {
        StOcioso    = 2'd0,
        StConcedido = 2'd1,
        StRetorno   = 2'd2
    } estado_e;

    estado_e             estado_q;
    logic [N_PORTAS-1:0] grant_q;
    logic [IdxW-1:0]     dono_q;
    logic                ocupado_q;
    logic [IdxW-1:0]     ultimo_q;
    logic [ContW-1:0]    cont_rajada_q;

    // Round-robin candidate: first writer found scanning ultimo+1, ultimo+2, ...
    logic                prox_valido;
    logic [IdxW-1:0]     prox_idx;
    logic [N_PORTAS-1:0] prox_grant;
    int unsigned         cand;

    // Scan all ports once, starting just after the last owner.
    always_comb begin
        prox_valido = 1'b0;
        prox_idx    = '0;
        cand        = 0;
        for (int unsigned k = 1; k <= N_PORTAS; k++) begin
            cand = (32'(ultimo_q) + k) % N_PORTAS;
            if (!prox_valido && req_escrita[cand]) begin
                prox_valido = 1'b1;
                prox_idx    = IdxW'(cand);
            end
        end
    end

    // One-hot form of the candidate, zero when nobody is requesting.
    always_comb begin
        prox_grant = '0;
        for (int unsigned i = 0; i < N_PORTAS; i++) begin
            prox_grant[i] = prox_valido && (prox_idx == IdxW'(i));
        end
    end

    // Some port other than the current owner wants the bus.
    logic outros_pedem;
    logic dono_pede;
    logic rajada_cheia;

    // Burst and release conditions evaluated while the bus is owned.
    always_comb begin
        outros_pedem = |(req_escrita & ~grant_q);
        dono_pede    = req_escrita[dono_q];
        rajada_cheia = (cont_rajada_q == ContW'(MAX_RAJADA));
    end

    // Arbitration FSM with registered grant, owner and busy flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q      <= StOcioso;
            grant_q       <= '0;
            dono_q        <= '0;
            ocupado_q     <= 1'b0;
            ultimo_q      <= IdxW'(N_PORTAS - 1);
            cont_rajada_q <= '0;
        end else begin
            unique case (estado_q)
                // Idle and turnaround share the same arbitration at their exit edge.
                StOcioso, StRetorno: begin
                    if (prox_valido) begin
                        estado_q      <= StConcedido;
                        grant_q       <= prox_grant;
                        dono_q        <= prox_idx;
                        ocupado_q     <= 1'b1;
                        cont_rajada_q <= ContW'(1);
                    end else begin
                        estado_q      <= StOcioso;
                        grant_q       <= '0;
                        ocupado_q     <= 1'b0;
                        cont_rajada_q <= '0;
                    end
                end
                StConcedido: begin
                    if (!dono_pede || (rajada_cheia && outros_pedem)) begin
                        estado_q      <= StRetorno;
                        ultimo_q      <= dono_q;
                        grant_q       <= '0;
                        ocupado_q     <= 1'b0;
                        cont_rajada_q <= '0;
                    end else if (rajada_cheia) begin
                        // Lone requester keeps the bus; restart the burst count.
                        cont_rajada_q <= ContW'(1);
                    end else begin
                        cont_rajada_q <= cont_rajada_q + ContW'(1);
                    end
                end
                default: begin
                    estado_q      <= StOcioso;
                    grant_q       <= '0;
                    ocupado_q     <= 1'b0;
                    cont_rajada_q <= '0;
                end
            endcase
        end
    end

    // Bus datapath: owner's data while it still writes, readers strobed except the owner.
    always_comb begin
        valido          = ocupado_q & req_escrita[dono_q];
        dado_barramento = valido ? dado_in[dono_q * LARGURA +: LARGURA] : '0;
        ler_en          = {N_PORTAS{valido}} & req_leitura & ~grant_q;
    end

    assign grant   = grant_q;
    assign dono    = dono_q;
    assign ocupado = ocupado_q;

endmodule
